// File: rtl/risc_controller.sv
// risc_controller: multi-cycle control FSM issuing ALUop, operand-select and
// register-file controls for the 16-bit ALU datapath, one instruction per start.
module risc_controller (
  input  logic        clk,
  input  logic        reset,
  input  logic        s,
  input  logic [15:0] in,
  output logic        w,
  output logic [2:0]  readnum,
  output logic [2:0]  writenum,
  output logic        write,
  output logic        loada,
  output logic        loadb,
  output logic        loadc,
  output logic        loads,
  output logic        asel,
  output logic        bsel,
  output logic        vsel,
  output logic [1:0]  ALUop,
  output logic [1:0]  shift,
  output logic [15:0] sximm8,
  output logic        err
);

  localparam int unsigned DW = 16;
  localparam int unsigned RW = 3;
  localparam int unsigned OW = 2;

  typedef enum logic [2:0] {
    S_WAIT, S_DECODE, S_GETA, S_GETB, S_EXEC, S_WRITE, S_WRITEIMM
  } state_t;

  typedef enum logic [2:0] {
    K_MOVI, K_MOVR, K_ADD, K_CMP, K_AND, K_MVN, K_ILL
  } kind_t;

  // Instruction class from {opc, op}
  function automatic kind_t classify(input logic [4:0] key);
    kind_t k;
    k = K_ILL;
    case (key)
      5'b110_10: k = K_MOVI;
      5'b110_00: k = K_MOVR;
      5'b101_00: k = K_ADD;
      5'b101_01: k = K_CMP;
      5'b101_10: k = K_AND;
      5'b101_11: k = K_MVN;
      default:   k = K_ILL;
    endcase
    return k;
  endfunction

  state_t        state, state_d;
  logic [DW-1:0] instr, instr_d;
  kind_t         kind, kind_d;

  logic          w_d, write_d, loada_d, loadb_d, loadc_d, loads_d;
  logic          asel_d, vsel_d, err_d;
  logic [RW-1:0] readnum_d, writenum_d;
  logic [OW-1:0] aluop_d, shift_d;

  assign kind   = classify(instr[15:11]);
  assign kind_d = classify(instr_d[15:11]);

  // Next state, instruction capture, and the Moore outputs of the next state
  always_comb begin
    state_d    = state;
    instr_d    = instr;
    err_d      = 1'b0;
    w_d        = 1'b0;
    readnum_d  = '0;
    writenum_d = '0;
    write_d    = 1'b0;
    loada_d    = 1'b0;
    loadb_d    = 1'b0;
    loadc_d    = 1'b0;
    loads_d    = 1'b0;
    asel_d     = 1'b0;
    vsel_d     = 1'b0;
    aluop_d    = '0;
    shift_d    = '0;

    case (state)
      S_WAIT: begin
        if (s) begin
          state_d = S_DECODE;
          instr_d = in;
          // err is visible during DECODE, so it is decided at acceptance
          err_d   = (classify(in[15:11]) == K_ILL);
        end
      end
      S_DECODE: begin
        case (kind)
          K_MOVI:              state_d = S_WRITEIMM;
          K_ADD, K_CMP, K_AND: state_d = S_GETA;
          K_MOVR, K_MVN:       state_d = S_GETB;
          default:             state_d = S_WAIT;
        endcase
      end
      S_GETA:  state_d = S_GETB;
      S_GETB:  state_d = S_EXEC;
      S_EXEC:  state_d = (kind == K_CMP) ? S_WAIT : S_WRITE;
      default: state_d = S_WAIT;
    endcase

    w_d = (state_d == S_WAIT);
    case (state_d)
      S_GETA: begin
        readnum_d = instr_d[10:8];
        loada_d   = 1'b1;
      end
      S_GETB: begin
        readnum_d = instr_d[2:0];
        loadb_d   = 1'b1;
      end
      S_EXEC: begin
        shift_d = instr_d[4:3];
        loadc_d = 1'b1;
        case (kind_d)
          K_ADD, K_AND: aluop_d = instr_d[12:11];
          K_CMP: begin
            aluop_d = 2'b01;
            loads_d = 1'b1;
            loadc_d = 1'b0;
          end
          K_MVN: begin
            aluop_d = 2'b11;
            asel_d  = 1'b1;
          end
          K_MOVR: begin
            aluop_d = 2'b00;
            asel_d  = 1'b1;
          end
          default: ;
        endcase
      end
      S_WRITE: begin
        writenum_d = instr_d[7:5];
        write_d    = 1'b1;
      end
      S_WRITEIMM: begin
        writenum_d = instr_d[10:8];
        vsel_d     = 1'b1;
        write_d    = 1'b1;
      end
      default: ;
    endcase
  end

  // State, instruction register and registered outputs; reset aborts to WAIT
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_WAIT;
      instr    <= '0;
      w        <= 1'b1;
      readnum  <= '0;
      writenum <= '0;
      write    <= 1'b0;
      loada    <= 1'b0;
      loadb    <= 1'b0;
      loadc    <= 1'b0;
      loads    <= 1'b0;
      asel     <= 1'b0;
      vsel     <= 1'b0;
      ALUop    <= '0;
      shift    <= '0;
      err      <= 1'b0;
    end else begin
      state    <= state_d;
      instr    <= instr_d;
      w        <= w_d;
      readnum  <= readnum_d;
      writenum <= writenum_d;
      write    <= write_d;
      loada    <= loada_d;
      loadb    <= loadb_d;
      loadc    <= loadc_d;
      loads    <= loads_d;
      asel     <= asel_d;
      vsel     <= vsel_d;
      ALUop    <= aluop_d;
      shift    <= shift_d;
      err      <= err_d;
    end
  end

  assign sximm8 = {{8{instr[7]}}, instr[7:0]};
  assign bsel   = 1'b0;

endmodule

// File: tb/tb_risc_controller.sv
// tb_risc_controller: directed and randomized instruction sequences checked
// cycle by cycle against a per-instruction expected-trace model.
module tb_risc_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        s;
  logic [15:0] in;
  logic        w, write, loada, loadb, loadc, loads, asel, bsel, vsel, err;
  logic [2:0]  readnum, writenum;
  logic [1:0]  ALUop, shift;
  logic [15:0] sximm8;

  risc_controller dut (
    .clk(clk), .reset(reset), .s(s), .in(in),
    .w(w), .readnum(readnum), .writenum(writenum), .write(write),
    .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads),
    .asel(asel), .bsel(bsel), .vsel(vsel), .ALUop(ALUop), .shift(shift),
    .sximm8(sximm8), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        w;
    logic [2:0]  readnum;
    logic [2:0]  writenum;
    logic        write;
    logic        loada;
    logic        loadb;
    logic        loadc;
    logic        loads;
    logic        asel;
    logic        bsel;
    logic        vsel;
    logic [1:0]  aluop;
    logic [1:0]  shift;
    logic        err;
    logic [15:0] sximm8;
  } ov_t;

  int          nvec = 0;
  int          nfail = 0;
  ov_t         exp_q[$];
  string       tag_q[$];
  logic [15:0] cur_sx = 16'h0000;

  function automatic ov_t observed();
    ov_t o;
    o.w = w; o.readnum = readnum; o.writenum = writenum; o.write = write;
    o.loada = loada; o.loadb = loadb; o.loadc = loadc; o.loads = loads;
    o.asel = asel; o.bsel = bsel; o.vsel = vsel; o.aluop = ALUop;
    o.shift = shift; o.err = err; o.sximm8 = sximm8;
    return o;
  endfunction

  function automatic ov_t blank(input logic [15:0] sx);
    ov_t v = '0;
    v.sximm8 = sx;
    return v;
  endfunction

  task automatic check(input string tag, input ov_t e);
    ov_t o;
    o = observed();
    nvec++;
    assert (o === e) else begin
      nfail++;
      $error("FAIL %s: observed %h required %h", tag, o, e);
    end
  endtask

  // Expected per-cycle trace of one instruction, from acceptance back to idle
  task automatic build(input logic [15:0] ins);
    string       m;
    ov_t         v;
    int          imm;
    logic [15:0] sx;
    logic [2:0]  rn, rd, rm;
    logic [1:0]  sh;
    case (ins[15:11])
      5'b11010: m = "MOVI";
      5'b11000: m = "MOVR";
      5'b10100: m = "ADD";
      5'b10101: m = "CMP";
      5'b10110: m = "AND";
      5'b10111: m = "MVN";
      default:  m = "ILL";
    endcase
    rn = ins[10:8]; rd = ins[7:5]; sh = ins[4:3]; rm = ins[2:0];
    imm = int'(ins[7:0]);
    sx = 16'((imm >= 128) ? imm + 65280 : imm);
    cur_sx = sx;

    v = blank(sx); v.err = (m == "ILL");
    exp_q.push_back(v); tag_q.push_back({m, "/decode"});
    if (m == "MOVI") begin
      v = blank(sx); v.writenum = rn; v.vsel = 1'b1; v.write = 1'b1;
      exp_q.push_back(v); tag_q.push_back({m, "/writeimm"});
    end else if (m != "ILL") begin
      if (m == "ADD" || m == "CMP" || m == "AND") begin
        v = blank(sx); v.readnum = rn; v.loada = 1'b1;
        exp_q.push_back(v); tag_q.push_back({m, "/geta"});
      end
      v = blank(sx); v.readnum = rm; v.loadb = 1'b1;
      exp_q.push_back(v); tag_q.push_back({m, "/getb"});
      v = blank(sx); v.shift = sh;
      v.aluop = (m == "CMP") ? 2'd1 : (m == "AND") ? 2'd2 : (m == "MVN") ? 2'd3 : 2'd0;
      v.asel  = (m == "MVN" || m == "MOVR");
      v.loads = (m == "CMP");
      v.loadc = (m != "CMP");
      exp_q.push_back(v); tag_q.push_back({m, "/exec"});
      if (m != "CMP") begin
        v = blank(sx); v.writenum = rd; v.write = 1'b1;
        exp_q.push_back(v); tag_q.push_back({m, "/write"});
      end
    end
    v = blank(sx); v.w = 1'b1;
    exp_q.push_back(v); tag_q.push_back({m, "/idle"});
  endtask

  // Accept ins now (called in a WAIT cycle) and check every cycle until idle
  task automatic run_instr(input logic [15:0] ins);
    build(ins);
    s = 1'b1; in = ins;
    while (exp_q.size() > 0) begin
      @(posedge clk); #1;
      s  = 1'($urandom_range(0, 1));
      in = 16'($urandom);
      check(tag_q.pop_front(), exp_q.pop_front());
    end
    s = 1'b0;
  endtask

  task automatic idle(input int n);
    ov_t v;
    repeat (n) begin
      @(posedge clk); #1;
      in = 16'($urandom);
      v = blank(cur_sx); v.w = 1'b1;
      check("idle_hold", v);
    end
  endtask

  logic [4:0]  legal_keys [6] = '{5'b11010, 5'b11000, 5'b10100, 5'b10101, 5'b10110, 5'b10111};
  logic [15:0] directed   [7] = '{16'hD007, 16'hD0FF, 16'hA140, 16'hA900, 16'hB864, 16'hC0AE, 16'hE000};

  initial begin
    ov_t         rv;
    logic [15:0] ins;
    reset = 1'b1; s = 1'b0; in = 16'h0000;
    repeat (2) @(posedge clk);
    #1;
    rv = blank(16'h0000); rv.w = 1'b1;
    check("reset_state", rv);
    reset = 1'b0;
    idle(2);

    // Directed instructions, back-to-back for the last few
    for (int i = 0; i < 7; i++) begin
      run_instr(directed[i]);
      if (i < 3) idle(1);
    end

    // Reset during GETB of ADD R2,R1,R0 aborts with no writeback
    build(16'hA140);
    s = 1'b1; in = 16'hA140;
    repeat (3) begin
      @(posedge clk); #1;
      s = 1'b0;
      check(tag_q.pop_front(), exp_q.pop_front());
    end
    exp_q.delete(); tag_q.delete();
    reset = 1'b1;
    #1;
    cur_sx = 16'h0000;
    rv = blank(16'h0000); rv.w = 1'b1;
    check("reset_abort", rv);
    @(posedge clk); #1;
    check("reset_held", rv);
    reset = 1'b0;
    idle(4);

    // Randomized instruction stream, mostly legal encodings
    for (int i = 0; i < 150; i++) begin
      ins = 16'($urandom);
      if ($urandom_range(0, 9) < 8) ins[15:11] = legal_keys[$urandom_range(0, 5)];
      run_instr(ins);
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
